// File: rtl/encoder_cardinal.sv
// Vector-ISA instruction encoder: packs instruction fields into 32-bit words
// and streams them into instruction memory through one registered write port.
module encoder_cardinal #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic              in_last,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_ra,
  input  logic [4:0]        in_rb,
  input  logic [1:0]        in_ww,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              bad_kind,
  output logic              wrap
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b101010;
  localparam logic [5:0] OP_VLD   = 6'b100000;
  localparam logic [5:0] OP_VSD   = 6'b100001;
  localparam logic [5:0] OP_VBEZ  = 6'b100010;
  localparam logic [5:0] OP_VBNEZ = 6'b100011;
  localparam logic [5:0] OP_VNOP  = 6'b111100;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                bad_q, bad_d;
  logic                wrap_q, wrap_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic                k_rtype;
  logic                k_mem;
  logic                k_br;
  logic                k_nop;
  logic [31:0]         enc_word;
  logic                enc_bad;
  logic                accept;

  assign k_rtype = (in_kind == 3'd0);
  assign k_mem   = (in_kind == 3'd1) || (in_kind == 3'd2);
  assign k_br    = (in_kind == 3'd3) || (in_kind == 3'd4);
  assign k_nop   = (in_kind == 3'd5);

  // Kinds 6/7 fall to default: they encode as VNOP and flag bad_kind.
  always_comb begin
    enc_word = {OP_VNOP, 26'b0};
    enc_bad  = 1'b0;
    unique case (1'b1)
      k_rtype: enc_word = {OP_RTYPE, in_rd, in_ra, in_rb,
                           3'b000, in_ww, in_funct};
      k_mem:   enc_word = {(in_kind == 3'd2) ? OP_VSD : OP_VLD,
                           in_rd, in_ra, in_imm};
      k_br:    enc_word = {(in_kind == 3'd4) ? OP_VBNEZ : OP_VBEZ,
                           in_rd, 5'b00000, in_imm};
      k_nop:   enc_word = {OP_VNOP, 26'b0};
      default: enc_bad  = 1'b1;
    endcase
  end

  assign in_ready = (state_q == RUN) && (!we_q || mem_gnt);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    bad_d   = bad_q;
    wrap_d  = wrap_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          ptr_d   = base_addr;
          count_d = '0;
          bad_d   = 1'b0;
          wrap_d  = 1'b0;
        end
      end
      RUN: begin
        if (we_q && mem_gnt) begin
          we_d = 1'b0;
        end
        // A grant and a new accept in the same cycle refill the register.
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = enc_word;
          ptr_d   = ptr_q + ADDR_W'(1);
          if (&ptr_q) begin
            wrap_d = 1'b1;
          end
          if (!(&count_q)) begin
            count_d = count_q + (ADDR_W+1)'(1);
          end
          if (enc_bad) begin
            bad_d = 1'b1;
          end
          if (in_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!we_q || mem_gnt) begin
          we_d    = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      bad_q   <= 1'b0;
      wrap_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      bad_q   <= bad_d;
      wrap_q  <= wrap_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign count     = count_q;
  assign bad_kind  = bad_q;
  assign wrap      = wrap_q;

endmodule

// File: doc/encoder_cardinal.md
ENCODER_CARDINAL -- requirements
Module: encoder_cardinal

Interface
REQ-001 Parameter: ADDR_W, default 8, instruction-memory word-address width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse beginning a program-load session.
REQ-005 base_addr  in  ADDR_W  first write address; sampled on accepted start.
REQ-006 in_valid  in  1  instruction fields present.
REQ-007 in_ready  out  1  encoder can accept fields this cycle.
REQ-008 in_kind  in  3  0=RTYPE, 1=VLD, 2=VSD, 3=VBEZ, 4=VBNEZ, 5=VNOP, 6-7 invalid.
REQ-009 in_last  in  1  marks final instruction of session.
REQ-010 in_rd, in_ra, in_rb  in  5 each  register fields.
REQ-011 in_ww  in  2  element width; in_funct  in  6  ALU function; in_imm  in  16  immediate.
REQ-012 mem_we  out  1  write request to instruction memory.
REQ-013 mem_addr  out  ADDR_W  write address; mem_wdata  out  32  encoded word.
REQ-014 mem_gnt  in  1  memory consumed the write this cycle.
REQ-015 busy  out  1  state != IDLE; done  out  1  one-cycle completion pulse.
REQ-016 count  out  ADDR_W+1  words accepted this session.
REQ-017 bad_kind  out  1  sticky: an invalid kind was seen; wrap  out  1  sticky: address wrapped.

Function
REQ-018 Opcodes: RTYPE 101010, VLD 100000, VSD 100001, VBEZ 100010, VBNEZ 100011, VNOP 111100, placed in bits [31:26].
REQ-019 RTYPE word SHALL be {op, rd[25:21], ra[20:16], rb[15:11], 3'b000[10:8], ww[7:6], funct[5:0]}.
REQ-020 VLD/VSD word SHALL be {op, rd, ra, imm[15:0]}.
REQ-021 VBEZ/VBNEZ word SHALL be {op, rd, 5'b00000, imm}; in_ra ignored.
REQ-022 VNOP word SHALL be {111100, 26'b0}; invalid kind SHALL encode as VNOP and set bad_kind.
REQ-023 FSM states IDLE, RUN, DRAIN, DONE.
REQ-024 IDLE: in_ready=0; start -> RUN, ptr<=base_addr, count<=0, bad_kind<=0, wrap<=0.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 RUN: in_ready = !mem_we || mem_gnt (combinational, single output register with backpressure).
REQ-027 Accept (in_valid && in_ready) in cycle N: cycle N+1 mem_we=1, mem_addr=ptr, mem_wdata=encoded word; ptr<=ptr+1; count<=count+1 (saturates at all-ones).
REQ-028 While mem_we && !mem_gnt, mem_addr and mem_wdata SHALL hold stable.
REQ-029 mem_gnt with no simultaneous accept SHALL clear mem_we next cycle; gnt plus accept SHALL keep mem_we=1 with new data (back-to-back, one word/cycle).
REQ-030 ptr at all-ones on accept SHALL wrap to 0 and set wrap; the write still occurs.
REQ-031 Accepting in_last -> DRAIN; DRAIN in_ready=0; leave to DONE when mem_we==0 or mem_gnt==1.
REQ-032 DONE: done=1 exactly one cycle, then IDLE; count, bad_kind, wrap held until next start.
REQ-033 mem_gnt while mem_we=0 SHALL be ignored.

Reset
REQ-034 reset asserted at any time, including mid-session, SHALL immediately force IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, busy=0, count=0, bad_kind=0, wrap=0, ptr=0; a pending write is discarded.

Verification
REQ-035 start base=0x10; RTYPE rd=3 ra=4 rb=5 ww=2 funct=0x01, last, gnt=1 -> mem_addr=0x10, mem_wdata=0xA86428 81, done one cycle after DRAIN, count=1.
REQ-036 VLD rd=1 ra=2 imm=0x0040 then VBNEZ rd=7 imm=0xFFFC, gnt tied 1 -> words 0x80220040, 0x8CE0FFFC at consecutive addresses, back-to-back cycles.
REQ-037 mem_gnt held 0 for 3 cycles with in_valid=1 -> in_ready=0, mem_addr/mem_wdata stable, no word lost or duplicated.
REQ-038 base=0xFF, two instructions -> addresses 0xFF then 0x00, wrap=1.
REQ-039 in_kind=7 -> word 0xF0000000, bad_kind=1 until next start.
REQ-040 reset pulsed while mem_we=1 in RUN -> all outputs zero next edge, start required to resume.
